// File: rtl/sha256_pkg.sv
// Constants and types shared by the SHA-256 message padder and the hash core.
//   num_blocks(words) : padded block count for a message of 'words' 32-bit words
//   PAD_WORD          : marker word appended right after the message
//   BLOCK_WORDS       : 32-bit words per 512-bit block
//   padder_state_e    : padder FSM states
//   SHA256_K, SHA256_H0..H7 : round constants and initial hash value
package sha256_pkg;

  localparam logic [31:0] PAD_WORD    = 32'h8000_0000;
  localparam int unsigned BLOCK_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    FINISH  = 2'd3
  } padder_state_e;

  // Message bits + marker bit + 64-bit length, rounded up to whole blocks.
  function automatic int unsigned num_blocks(input int unsigned words);
    return (words * 32 + 64 + 1 + 511) / 512;
  endfunction

  localparam logic [31:0] SHA256_K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] SHA256_H0 = 32'h6a09e667;
  localparam logic [31:0] SHA256_H1 = 32'hbb67ae85;
  localparam logic [31:0] SHA256_H2 = 32'h3c6ef372;
  localparam logic [31:0] SHA256_H3 = 32'ha54ff53a;
  localparam logic [31:0] SHA256_H4 = 32'h510e527f;
  localparam logic [31:0] SHA256_H5 = 32'h9b05688c;
  localparam logic [31:0] SHA256_H6 = 32'h1f83d9ab;
  localparam logic [31:0] SHA256_H7 = 32'h5be0cd19;

endpackage

// File: rtl/sha256_pad_word.sv
// Maps a global slot index to the word that belongs in that slot of the
// padded message: message word, marker, length, or zero.
// Optional build macro SHA256_PAD_BYTESWAP_EN byte-reverses message words.
// Ports:
//   g           : global slot index (blk_index*16 + w)
//   mem_word    : memory word fetched for slot g (ignored for pad slots)
//   slot_word_c : combinational slot content
module sha256_pad_word
  import sha256_pkg::*;
#(
  parameter int unsigned NUM_OF_WORDS = 20
) (
  input  logic [15:0] g,
  input  logic [31:0] mem_word,
  output logic [31:0] slot_word_c
);

  localparam int unsigned NUM_BLOCKS  = num_blocks(NUM_OF_WORDS);
  localparam logic [15:0] MSG_WORDS   = 16'(NUM_OF_WORDS);
  localparam logic [15:0] LEN_LO_SLOT = 16'(16 * NUM_BLOCKS - 1);
  // Bit length is 16-bit arithmetic, so the upper length word is always zero.
  localparam logic [31:0] LEN_LO      = 32'(16'(NUM_OF_WORDS * 32));

  logic [31:0] msg_word;

`ifdef SHA256_PAD_BYTESWAP_EN
  assign msg_word = {mem_word[7:0], mem_word[15:8], mem_word[23:16], mem_word[31:24]};
`else
  assign msg_word = mem_word;
`endif

  // Slot selection; the upper length slot falls through to zero.
  always_comb begin
    slot_word_c = '0;
    if (g < MSG_WORDS) begin
      slot_word_c = msg_word;
    end else if (g == MSG_WORDS) begin
      slot_word_c = PAD_WORD;
    end else if (g == LEN_LO_SLOT) begin
      slot_word_c = LEN_LO;
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// Reads an NUM_OF_WORDS-word message from memory, applies SHA-256 padding
// and presents it as 512-bit blocks on a valid/ready handshake.
// Optional build macro SHA256_PAD_BYTESWAP_EN byte-reverses message words.
// Ports:
//   clk, reset_n      : clock, async active-low reset
//   start             : begin a message (sampled in IDLE only)
//   message_addr      : word address of message word 0, latched on start
//   mem_clk, mem_we   : memory clock (= clk), write enable (always 0)
//   mem_addr          : memory read address
//   mem_read_data     : read data, one clk after mem_addr
//   blk_valid/ready   : block handshake
//   blk_data          : block, word 0 in [511:480]
//   blk_last          : current block is the final one
//   blk_index         : 0-based block number
//   busy, done        : not idle; one-cycle pulse after final handshake
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int unsigned NUM_OF_WORDS = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [15:0]  message_addr,
  output logic         mem_clk,
  output logic         mem_we,
  output logic [15:0]  mem_addr,
  input  logic [31:0]  mem_read_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_last,
  output logic [7:0]   blk_index,
  output logic         busy,
  output logic         done
);

  localparam int unsigned NUM_BLOCKS = num_blocks(NUM_OF_WORDS);
  localparam logic [7:0]  LAST_INDEX = 8'(NUM_BLOCKS - 1);
  localparam logic [15:0] MSG_WORDS  = 16'(NUM_OF_WORDS);

  padder_state_e state;
  logic [4:0]    cnt;
  logic [15:0]   base;
  logic [15:0]   wr_g;
  logic [15:0]   iss_g;
  logic [15:0]   nxt_g;
  logic [31:0]   slot_word_c;

  assign mem_clk = clk;
  assign mem_we  = 1'b0;

  // Slot written this cycle (issued last cycle), slot issued next cycle,
  // and first slot of the following block.
  assign wr_g  = {4'b0000, blk_index, cnt[3:0] - 4'd1};
  assign iss_g = {4'b0000, blk_index, cnt[3:0] + 4'd1};
  assign nxt_g = {4'b0000, blk_index + 8'd1, 4'b0000};

  sha256_pad_word #(
    .NUM_OF_WORDS (NUM_OF_WORDS)
  ) u_pad_word (
    .g           (wr_g),
    .mem_word    (mem_read_data),
    .slot_word_c (slot_word_c)
  );

  // Control FSM; slot 0 of a block is issued on the edge entering FETCH,
  // so FETCH cycle c issues slot c and writes slot c-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      base      <= '0;
      mem_addr  <= '0;
      blk_valid <= 1'b0;
      blk_data  <= '0;
      blk_last  <= 1'b0;
      blk_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base      <= message_addr;
            mem_addr  <= message_addr;
            blk_index <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          // Past the message the address simply holds; pad slots need no read.
          if (cnt <= 5'd14 && iss_g < MSG_WORDS) begin
            mem_addr <= base + iss_g;
          end
          if (cnt != 5'd0) begin
            blk_data <= {blk_data[479:0], slot_word_c};
          end
          if (cnt == 5'd16) begin
            cnt       <= '0;
            blk_valid <= 1'b1;
            blk_last  <= (blk_index == LAST_INDEX);
            state     <= PRESENT;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        PRESENT: begin
          if (blk_ready) begin
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            if (blk_last) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              blk_index <= blk_index + 8'd1;
              cnt       <= '0;
              if (nxt_g < MSG_WORDS) begin
                mem_addr <= base + nxt_g;
              end
              state <= FETCH;
            end
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: two instances (20 and 14 words),
// expected blocks queued at start, compared on each handshake.
module tb_sha256_msg_padder;

  typedef struct {
    logic [511:0] data;
    logic         last;
    logic [7:0]   idx;
  } blk_t;

  // Edges from the start/handshake sampling edge to the edge raising blk_valid
  // (18 edges counting the sampling edge itself).
  localparam int LAT = 17;

  logic clk, reset_n;

  logic         start20, v20, rdy20, last20, busy20, done20, mclk20, we20;
  logic [15:0]  addr20, maddr20;
  logic [31:0]  rd20;
  logic [511:0] data20;
  logic [7:0]   idx20;

  logic         start14, v14, rdy14, last14, busy14, done14, mclk14, we14;
  logic [15:0]  addr14, maddr14;
  logic [31:0]  rd14;
  logic [511:0] data14;
  logic [7:0]   idx14;

  logic [31:0] mem [0:65535];

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int t_ref20 = 0, t_ref14 = 0;
  int hs_cnt20 = 0, hs_cnt14 = 0, done_cnt20 = 0, done_cnt14 = 0;
  blk_t q20[$], q14[$];

  sha256_msg_padder #(.NUM_OF_WORDS(20)) u_dut20 (
    .clk(clk), .reset_n(reset_n), .start(start20), .message_addr(addr20),
    .mem_clk(mclk20), .mem_we(we20), .mem_addr(maddr20), .mem_read_data(rd20),
    .blk_valid(v20), .blk_ready(rdy20), .blk_data(data20), .blk_last(last20),
    .blk_index(idx20), .busy(busy20), .done(done20)
  );

  sha256_msg_padder #(.NUM_OF_WORDS(14)) u_dut14 (
    .clk(clk), .reset_n(reset_n), .start(start14), .message_addr(addr14),
    .mem_clk(mclk14), .mem_we(we14), .mem_addr(maddr14), .mem_read_data(rd14),
    .blk_valid(v14), .blk_ready(rdy14), .blk_data(data14), .blk_last(last14),
    .blk_index(idx14), .busy(busy14), .done(done14)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Synchronous-read memory model: data one clk after the address.
  always @(posedge clk) begin
    rd20 <= mem[maddr20];
    rd14 <= mem[maddr14];
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nblocks(input int n);
    return (n * 32 + 64 + 1 + 511) / 512;
  endfunction

  function automatic logic [31:0] model_word(input int n, input logic [15:0] base, input int g);
    logic [31:0] m;
    if (g < n) begin
      m = mem[base + 16'(g)];
`ifdef SHA256_PAD_BYTESWAP_EN
      m = {m[7:0], m[15:8], m[23:16], m[31:24]};
`endif
      return m;
    end
    if (g == n) return 32'h8000_0000;
    if (g == 16 * nblocks(n) - 1) return 32'(n * 32);
    return 32'h0;
  endfunction

  function automatic blk_t model_block(input int n, input logic [15:0] base, input int b);
    blk_t e;
    e.data = '0;
    for (int w = 0; w < 16; w++) e.data[511 - 32 * w -: 32] = model_word(n, base, b * 16 + w);
    e.last = (b == nblocks(n) - 1);
    e.idx  = 8'(b);
    return e;
  endfunction

  // Scoreboard monitor, 20-word instance.
  initial begin : mon20
    logic prev_v, pend_done;
    blk_t e;
    prev_v = 1'b0;
    pend_done = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        prev_v = 1'b0;
        pend_done = 1'b0;
      end else begin
        if (done20 || pend_done) chk("done20", 512'(done20), 512'(pend_done));
        if (done20) done_cnt20++;
        pend_done = 1'b0;
        if (v20 && !prev_v) chk("lat20", 512'(cyc - t_ref20), 512'(LAT));
        prev_v = v20;
        if (v20 && rdy20) begin
          if (q20.size() == 0) begin
            chk("unexp20", 512'(1), 512'(0));
          end else begin
            e = q20.pop_front();
            chk("data20", data20, e.data);
            chk("last20", 512'(last20), 512'(e.last));
            chk("idx20", 512'(idx20), 512'(e.idx));
            hs_cnt20++;
            t_ref20 = cyc + 1;
            pend_done = e.last;
          end
        end
      end
    end
  end

  // Scoreboard monitor, 14-word instance.
  initial begin : mon14
    logic prev_v, pend_done;
    blk_t e;
    prev_v = 1'b0;
    pend_done = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        prev_v = 1'b0;
        pend_done = 1'b0;
      end else begin
        if (done14 || pend_done) chk("done14", 512'(done14), 512'(pend_done));
        if (done14) done_cnt14++;
        pend_done = 1'b0;
        if (v14 && !prev_v) chk("lat14", 512'(cyc - t_ref14), 512'(LAT));
        prev_v = v14;
        if (v14 && rdy14) begin
          if (q14.size() == 0) begin
            chk("unexp14", 512'(1), 512'(0));
          end else begin
            e = q14.pop_front();
            chk("data14", data14, e.data);
            chk("last14", 512'(last14), 512'(e.last));
            chk("idx14", 512'(idx14), 512'(e.idx));
            hs_cnt14++;
            t_ref14 = cyc + 1;
            pend_done = e.last;
          end
        end
      end
    end
  end

  task automatic run20(input logic [15:0] base);
    for (int b = 0; b < nblocks(20); b++) q20.push_back(model_block(20, base, b));
    @(negedge clk);
    start20 = 1'b1;
    addr20  = base;
    t_ref20 = cyc + 1;
    @(negedge clk);
    start20 = 1'b0;
    addr20  = 16'(~base);
  endtask

  task automatic pulse_start20(input logic [15:0] a);
    start20 = 1'b1;
    addr20  = a;
    @(negedge clk);
    start20 = 1'b0;
  endtask

  task automatic wait_done20(input int budget);
    int d0;
    d0 = done_cnt20;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt20 != d0) return;
    end
    chk("timeout20", 512'(0), 512'(1));
  endtask

  task automatic wait_valid20(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (v20) return;
      @(negedge clk);
    end
    chk("wait_valid20", 512'(0), 512'(1));
  endtask

  task automatic chk_reset20(input string tag);
    chk({tag, "_valid"}, 512'(v20), 512'(0));
    chk({tag, "_last"}, 512'(last20), 512'(0));
    chk({tag, "_index"}, 512'(idx20), 512'(0));
    chk({tag, "_data"}, data20, 512'(0));
    chk({tag, "_addr"}, 512'(maddr20), 512'(0));
    chk({tag, "_busy"}, 512'(busy20), 512'(0));
    chk({tag, "_done"}, 512'(done20), 512'(0));
    chk({tag, "_we"}, 512'(we20), 512'(0));
  endtask

  initial begin : safety
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin : main
    int h0, d0;
    logic [511:0] hold_data;
    logic [15:0]  hold_addr;

    for (int a = 0; a < 65536; a++) mem[a] = 32'(a) + 32'd1;
    mem[16'hFFFE] = 32'h1122_3344;
    mem[16'hFFFF] = 32'hA5A5_0001;

    reset_n = 1'b0;
    start20 = 1'b0; addr20 = '0; rdy20 = 1'b1;
    start14 = 1'b0; addr14 = '0; rdy14 = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset20("rst");
    chk("rst_memclk", 512'(mclk20), 512'(clk));
    chk("rst14_valid", 512'(v14), 512'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 20 words from address 0, ready held high.
    h0 = hs_cnt20; d0 = done_cnt20;
    run20(16'h0000);
    wait_done20(200);
    chk("t1_blocks", 512'(hs_cnt20 - h0), 512'(2));
    chk("t1_dones", 512'(done_cnt20 - d0), 512'(1));
    @(negedge clk);
    chk("t1_busy", 512'(busy20), 512'(0));

    // Backpressure on block 0.
    rdy20 = 1'b0;
    run20(16'h0100);
    wait_valid20(40);
    hold_data = data20;
    hold_addr = maddr20;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 512'(v20), 512'(1));
      chk("bp_data", data20, hold_data);
      chk("bp_addr", 512'(maddr20), 512'(hold_addr));
      chk("bp_done", 512'(done20), 512'(0));
    end
    rdy20 = 1'b1;
    wait_done20(200);

    // Reset during block-1 fetch, then a fresh message.
    h0 = hs_cnt20;
    run20(16'h0040);
    for (int i = 0; i < 60 && hs_cnt20 == h0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    q20.delete();
    #1;
    chk_reset20("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_idle", 512'(busy20), 512'(0));
    h0 = hs_cnt20; d0 = done_cnt20;
    run20(16'h0080);
    wait_done20(200);
    chk("t4_blocks", 512'(hs_cnt20 - h0), 512'(2));
    chk("t4_dones", 512'(done_cnt20 - d0), 512'(1));

    // Starts while busy, in PRESENT and in FINISH are all ignored.
    h0 = hs_cnt20; d0 = done_cnt20;
    run20(16'h0200);
    repeat (5) @(negedge clk);
    pulse_start20(16'h3000);
    wait_valid20(40);
    pulse_start20(16'h3100);
    for (int i = 0; i < 60 && !done20; i++) @(negedge clk);
    chk("t5_done_seen", 512'(done20), 512'(1));
    pulse_start20(16'h3200);
    repeat (25) @(negedge clk);
    chk("t5_busy", 512'(busy20), 512'(0));
    chk("t5_blocks", 512'(hs_cnt20 - h0), 512'(2));
    chk("t5_dones", 512'(done_cnt20 - d0), 512'(1));

    // Address wrap from 0xFFFE.
    run20(16'hFFFE);
    wait_done20(200);

    // 14-word instance: marker in slot 14, length alone in block 1.
    h0 = hs_cnt14;
    for (int b = 0; b < nblocks(14); b++) q14.push_back(model_block(14, 16'h0010, b));
    @(negedge clk);
    start14 = 1'b1;
    addr14  = 16'h0010;
    t_ref14 = cyc + 1;
    @(negedge clk);
    start14 = 1'b0;
    for (int i = 0; i < 200 && done_cnt14 == 0; i++) @(negedge clk);
    chk("t2_dones", 512'(done_cnt14), 512'(1));
    chk("t2_blocks", 512'(hs_cnt14 - h0), 512'(2));

    repeat (3) @(negedge clk);
    chk("q20_empty", 512'(q20.size()), 512'(0));
    chk("q14_empty", 512'(q14.size()), 512'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
